// File: rtl/ram_responder.sv
// Word-addressed 64-bit RAM responder: masked writes, fixed-latency pipelined reads,
// and sticky/saturating tracking of accesses outside the mapped window.
module ram_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_rd_en,
  input  logic [63:0] ram_rd_addr,
  output logic [63:0] ram_rd_data,
  output logic        ram_rd_valid,
  input  logic        ram_wr_en,
  input  logic [63:0] ram_wr_addr,
  input  logic [63:0] ram_wr_mask,
  input  logic [63:0] ram_wr_data,
  output logic        oob_err,
  output logic [15:0] oob_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  logic [63:0]       mem_q [DEPTH];
  logic [63:0]       rd_off_s, wr_off_s;
  logic              rd_in_s, wr_in_s;
  logic [AW-1:0]     rd_idx_s, wr_idx_s;
  logic              rd_oob_s, wr_oob_s;
  logic [1:0]        inc_s;
  logic [16:0]       sum_s;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [63:0]       dat_q [RD_LAT];
  logic [63:0]       dat_d [RD_LAT];
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  // Address decode: offset from base wraps, so a below-base address is caught by the compare.
  always_comb begin
    rd_off_s = ram_rd_addr - BASE_ADDR;
    wr_off_s = ram_wr_addr - BASE_ADDR;
    rd_in_s  = (ram_rd_addr >= BASE_ADDR) && (rd_off_s < SPAN);
    wr_in_s  = (ram_wr_addr >= BASE_ADDR) && (wr_off_s < SPAN);
    rd_idx_s = rd_off_s[3 +: AW];
    wr_idx_s = wr_off_s[3 +: AW];
    rd_oob_s = ram_rd_en & ~rd_in_s;
    wr_oob_s = ram_wr_en & ~wr_in_s;
  end

  // Read pipeline next state; each data stage only loads when a valid response moves in,
  // so the output data holds its last value through idle cycles.
  always_comb begin
    vld_d[0] = ram_rd_en;
    dat_d[0] = dat_q[0];
    if (ram_rd_en) begin
      dat_d[0] = rd_in_s ? mem_q[rd_idx_s] : 64'd0;
    end else begin
      dat_d[0] = dat_q[0];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
      end else begin
        dat_d[k] = dat_q[k];
      end
    end
  end

  // Out-of-range counter: up to two events per edge, saturating.
  always_comb begin
    inc_s = {1'b0, rd_oob_s} + {1'b0, wr_oob_s};
    sum_s = {1'b0, cnt_q} + {15'd0, inc_s};
    if (sum_s[16]) begin
      cnt_d = 16'hFFFF;
    end else begin
      cnt_d = sum_s[15:0];
    end
    err_d = err_q | (inc_s != 2'd0);
  end

  // Pipeline and error state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= 64'd0;
      end
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= dat_d[k];
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately outside reset; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (ram_wr_en && wr_in_s) begin
      mem_q[wr_idx_s] <= (mem_q[wr_idx_s] & ~ram_wr_mask) | (ram_wr_data & ram_wr_mask);
    end
  end

  assign ram_rd_valid = vld_q[RD_LAT-1];
  assign ram_rd_data  = dat_q[RD_LAT-1];
  assign oob_cnt      = cnt_q;
  assign oob_err      = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: three responders (read latency 1, 2, 3) share one directed stimulus stream;
// a negedge monitor per lane checks response data and arrival cycle.
module tb_ram_responder;

  localparam int DEPTH = 64;
  localparam int LATS [3] = '{1, 2, 3};

  typedef struct packed {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [63:0] rd_addr;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [63:0] wr_mask;
  logic [63:0] wr_data;
  logic        vld  [3];
  logic [63:0] rdd  [3];
  logic        oerr [3];
  logic [15:0] ocnt [3];

  exp_t sb [3][$];
  int   cyc  = 0;
  int   nchk = 0;
  int   nerr = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  ram_responder #(.DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .ram_rd_en(rd_en), .ram_rd_addr(rd_addr),
    .ram_rd_data(rdd[0]), .ram_rd_valid(vld[0]), .ram_wr_en(wr_en), .ram_wr_addr(wr_addr),
    .ram_wr_mask(wr_mask), .ram_wr_data(wr_data), .oob_err(oerr[0]), .oob_cnt(ocnt[0]));

  ram_responder #(.DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .ram_rd_en(rd_en), .ram_rd_addr(rd_addr),
    .ram_rd_data(rdd[1]), .ram_rd_valid(vld[1]), .ram_wr_en(wr_en), .ram_wr_addr(wr_addr),
    .ram_wr_mask(wr_mask), .ram_wr_data(wr_data), .oob_err(oerr[1]), .oob_cnt(ocnt[1]));

  ram_responder #(.DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .ram_rd_en(rd_en), .ram_rd_addr(rd_addr),
    .ram_rd_data(rdd[2]), .ram_rd_valid(vld[2]), .ram_wr_en(wr_en), .ram_wr_addr(wr_addr),
    .ram_wr_mask(wr_mask), .ram_wr_data(wr_data), .oob_err(oerr[2]), .oob_cnt(ocnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop on every valid, check data and arrival cycle; flag spurious or missing responses.
  always @(negedge clk) begin
    exp_t e;
    for (int l = 0; l < 3; l++) begin
      if (vld[l] === 1'b1) begin
        if (sb[l].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_valid lane%0d: got valid=1 data %h expected no response (cycle %0d)",
                   l, rdd[l], cyc);
        end else begin
          e = sb[l].pop_front();
          chk($sformatf("rd_data lane%0d", l), rdd[l], e.data);
          chk($sformatf("rd_cycle lane%0d", l), 64'(cyc), 64'(e.due));
        end
      end else if (sb[l].size() != 0 && sb[l][0].due <= cyc) begin
        nchk++;
        nerr++;
        $display("FAIL missing_valid lane%0d: got valid=%b expected data %h at cycle %0d",
                 l, vld[l], sb[l][0].data, sb[l][0].due);
        e = sb[l].pop_front();
      end
    end
  end

  task automatic step(input logic re, input logic [63:0] ra, input logic we, input logic [63:0] wa,
                      input logic [63:0] wm, input logic [63:0] wd, input logic [63:0] exp);
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_mask = wm;
    wr_data = wd;
    if (re) begin
      for (int l = 0; l < 3; l++) begin
        sb[l].push_back('{due: cyc + LATS[l], data: exp});
      end
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_err(input string nm, input logic [15:0] cnt, input logic err);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("%s_cnt lane%0d", nm, l), 64'(ocnt[l]), 64'(cnt));
      chk($sformatf("%s_err lane%0d", nm, l), 64'(oerr[l]), 64'(err));
    end
  endtask

  initial begin
    rst = 1'b0;
    rd_en = 1'b0; rd_addr = 64'd0; wr_en = 1'b0; wr_addr = 64'd0; wr_mask = 64'd0; wr_data = 64'd0;
    idle(3);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("rst_valid lane%0d", l), 64'(vld[l]), 64'd0);
      chk($sformatf("rst_data lane%0d", l), rdd[l], 64'd0);
    end
    chk_err("rst", 16'd0, 1'b0);
    rst = 1'b1;
    idle(2);

    // Full write then read
    step(1'b0, 64'd0, 1'b1, 64'h8000_0010, ONES, 64'hDEAD_BEEF_0123_4567, 64'd0);
    step(1'b1, 64'h8000_0010, 1'b0, 64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF_0123_4567);
    idle(4);

    // Partial mask, zero mask, and ignored low address bits
    step(1'b0, 64'd0, 1'b1, 64'h8000_0020, ONES, 64'h1111_1111_1111_1111, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'h8000_0020, 64'h0000_0000_FFFF_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0);
    step(1'b1, 64'h8000_0020, 1'b0, 64'd0, 64'd0, 64'd0, 64'h1111_1111_AAAA_1111);
    step(1'b0, 64'd0, 1'b1, 64'h8000_0020, 64'd0, ONES, 64'd0);
    step(1'b1, 64'h8000_0025, 1'b0, 64'd0, 64'd0, 64'd0, 64'h1111_1111_AAAA_1111);
    idle(4);

    // Same-edge read/write collision is read-first
    step(1'b0, 64'd0, 1'b1, 64'h8000_0030, ONES, 64'h5, 64'd0);
    step(1'b1, 64'h8000_0030, 1'b1, 64'h8000_0030, ONES, 64'h9, 64'h5);
    step(1'b1, 64'h8000_0030, 1'b0, 64'd0, 64'd0, 64'd0, 64'h9);
    idle(4);

    // Back-to-back reads of words 0..2, then top in-range word
    step(1'b0, 64'd0, 1'b1, 64'h8000_0000, ONES, 64'hA0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'h8000_0008, ONES, 64'hA1, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'h8000_0010, ONES, 64'hA2, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'h8000_01F8, ONES, 64'h77, 64'd0);
    step(1'b1, 64'h8000_0000, 1'b0, 64'd0, 64'd0, 64'd0, 64'hA0);
    step(1'b1, 64'h8000_0008, 1'b0, 64'd0, 64'd0, 64'd0, 64'hA1);
    step(1'b1, 64'h8000_0010, 1'b0, 64'd0, 64'd0, 64'd0, 64'hA2);
    idle(5);
    step(1'b1, 64'h8000_01F8, 1'b0, 64'd0, 64'd0, 64'd0, 64'h77);
    idle(4);
    chk_err("inrange", 16'd0, 1'b0);

    // Out-of-range read below base and write one past the end, same edge
    step(1'b1, 64'h7FFF_FFF8, 1'b1, 64'h8000_0200, ONES, ONES, 64'd0);
    chk_err("oob2", 16'd2, 1'b1);
    step(1'b1, 64'h8000_0000, 1'b0, 64'd0, 64'd0, 64'd0, 64'hA0);
    step(1'b0, 64'h7FFF_FFF8, 1'b0, 64'h8000_0200, ONES, ONES, 64'd0);
    chk_err("disabled", 16'd2, 1'b1);
    idle(4);

    // Drive the counter to saturation
    for (int i = 0; i < 32766; i++) begin
      step(1'b1, 64'h7FFF_FFF8, 1'b1, 64'h8000_0200, ONES, ONES, 64'd0);
    end
    chk_err("near_sat", 16'hFFFE, 1'b1);
    step(1'b1, 64'h7FFF_FFF8, 1'b1, 64'h8000_0200, ONES, ONES, 64'd0);
    chk_err("sat", 16'hFFFF, 1'b1);
    step(1'b0, 64'd0, 1'b1, 64'h8000_0200, ONES, ONES, 64'd0);
    chk_err("sat_hold", 16'hFFFF, 1'b1);
    idle(4);

    // Reset with a read in flight: response is dropped, contents survive
    step(1'b0, 64'd0, 1'b1, 64'h8000_0040, ONES, 64'h1234, 64'd0);
    step(1'b1, 64'h8000_0040, 1'b0, 64'd0, 64'd0, 64'd0, 64'h1234);
    rst = 1'b0;
    for (int l = 0; l < 3; l++) begin
      sb[l].delete();
    end
    idle(4);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("mid_rst_valid lane%0d", l), 64'(vld[l]), 64'd0);
      chk($sformatf("mid_rst_data lane%0d", l), rdd[l], 64'd0);
    end
    chk_err("mid_rst", 16'd0, 1'b0);
    rst = 1'b1;
    idle(1);
    step(1'b1, 64'h8000_0040, 1'b0, 64'd0, 64'd0, 64'd0, 64'h1234);
    step(1'b1, 64'h8000_0010, 1'b0, 64'd0, 64'd0, 64'd0, 64'hA2);
    step(1'b1, 64'h8000_01F8, 1'b0, 64'd0, 64'd0, 64'd0, 64'h77);
    idle(6);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("sb_drained lane%0d", l), 64'(sb[l].size()), 64'd0);
    end
    chk_err("final", 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the core's instruction/data RAM port: answers the core's read requests and commits its masked write requests.
- Owns a word-addressed 64-bit storage array behind a fixed base address.
- Returns read data through a parameterised fixed-latency pipeline with a valid strobe.
- Flags and counts out-of-range accesses. Sits between the core and the simulation top level, replacing the external virtual RAM.

Parameters:
- DEPTH, 4096, number of 64-bit words; power of two, ≥2.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address mapped to word 0.
- RD_LAT, 1, read latency in cycles from request to data; legal range 1..4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ram_rd_en  input  1  read request this cycle.
- ram_rd_addr  input  64  byte address of the read.
- ram_rd_data  output  64  read data; meaningful only while ram_rd_valid=1.
- ram_rd_valid  output  1  ram_rd_data carries the response to the request RD_LAT cycles earlier.
- ram_wr_en  input  1  write request this cycle.
- ram_wr_addr  input  64  byte address of the write.
- ram_wr_mask  input  64  bit-granular write mask; 1 = replace that bit.
- ram_wr_data  input  64  write data.
- oob_err  output  1  sticky: set by any out-of-range request.
- oob_cnt  output  16  count of out-of-range requests; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - ram_rd_valid=0, ram_rd_data=0, oob_err=0, oob_cnt=0.
  - All read-pipeline stages are invalidated; in-flight reads are dropped and never return.
  - Array contents are not reset and are preserved across reset.
- Address decode:
  - off = addr - BASE_ADDR (64-bit, wrapping).
  - In range iff addr ≥ BASE_ADDR and off < DEPTH*8.
  - Word index = off[3 +: log2(DEPTH)]; off[2:0] is ignored (no misalignment fault).
- Read:
  - Issued on a rising edge with ram_rd_en=1; one read accepted per cycle, fully pipelined, no back-pressure.
  - Array is sampled at the issue edge.
  - ram_rd_valid and ram_rd_data are registered outputs, updated RD_LAT edges after the issue edge (RD_LAT=1: valid in the cycle after the request).
  - An out-of-range read still returns, with valid=1 and data=64'h0.
  - ram_rd_valid is 0 in every cycle that has no response. ram_rd_data holds its last value while valid=0.
- Write:
  - On a rising edge with ram_wr_en=1 and an in-range address: mem[idx] <= (mem[idx] & ~mask) | (wr_data & mask).
  - mask=0 is a legal no-op. An out-of-range write is dropped.
- Same-edge read and write to the same word: read-first. The read returns the pre-write contents; the write lands at that edge.
- Back-to-back: a read issued the edge after a write to the same word returns the merged data.
- Error tracking:
  - Per edge, oob_cnt increments by (rd_en & rd_oob) + (wr_en & wr_oob), i.e. 0, 1 or 2.
  - Saturating: if the sum would exceed 16'hFFFF, oob_cnt holds 16'hFFFF.
  - oob_err <= 1 whenever the increment is nonzero; cleared only by reset.
- Requests with en=0 are ignored regardless of address or data values; X on the address is tolerated.

Test Plan:
1. RD_LAT=1, reset deasserted. Write addr 0x8000_0010, mask all-ones, data 0xDEAD_BEEF_0123_4567; next cycle read 0x8000_0010 -> one cycle later valid=1, data=0xDEAD_BEEF_0123_4567.
2. Partial mask: word holds 0x1111_1111_1111_1111. Write mask 0x0000_0000_FFFF_0000, data 0xAAAA_AAAA_AAAA_AAAA -> read returns 0x1111_1111_AAAA_1111.
3. Same-edge collision: word holds 0x5; read and write (data 0x9, full mask) on the same edge -> that read returns 0x5; a read on the next edge returns 0x9.
4. RD_LAT=3: reads to words 0,1,2 on consecutive edges -> valid high exactly 3 consecutive cycles, starting 3 edges after the first request, with data in order; valid=0 otherwise.
5. Out of range: read 0x7FFF_FFF8 and, on the same edge, write BASE+DEPTH*8 -> oob_cnt 0->2, oob_err=1, read returns 0 with valid=1, array unchanged. Preload oob_cnt near saturation via repeated errors -> it stops at 0xFFFF.
6. Reset mid-operation, RD_LAT=2: issue a read, then assert rst before it returns -> valid stays 0, no late response, oob_cnt=0. After rst deasserts, earlier-written data is still readable.
